// File: rtl/alu_defs.sv
// Shared definitions for the ALU issue controller: opcode map, command bus
// width and FSM state encoding.
package alu_defs;

    localparam int OPC_W   = 5;
    localparam int NUM_OPS = 6;
    localparam int CMD_W   = 6;

    localparam logic [OPC_W-1:0] OP_ADD = 5'd0;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd1;
    localparam logic [OPC_W-1:0] OP_AND = 5'd2;
    localparam logic [OPC_W-1:0] OP_OR  = 5'd3;
    localparam logic [OPC_W-1:0] OP_SLL = 5'd4;
    localparam logic [OPC_W-1:0] OP_SRA = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only the adder/subtractor produces a meaningful overflow flag.
    function automatic logic op_has_overflow(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: 5-bit opcode to one-hot ALU command plus an
// illegal-opcode flag for anything outside the implemented set.
module alu_op_decode
    import alu_defs::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic [CMD_W-1:0] command,
    output logic             illegal
);

    // One command line per implemented operation.
    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_cmd
            assign command[gi] = (opcode == OPC_W'(gi));
        end
    endgenerate

    assign illegal = (opcode >= OPC_W'(NUM_OPS));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the simple ALU: accepts one request per
// handshake, drives the one-hot command and latched operands for the ALU's
// latency, then captures and holds the result for the downstream consumer.
module alu_issue_ctrl
    import alu_defs::*;
#(
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [CMD_W-1:0] alu_command,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic             out_error
);

    // A zero-latency ALU still needs a one-bit counter to keep the logic uniform.
    localparam int CNT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ovf_en_reg;

    logic [CMD_W-1:0]   dec_command;
    logic               dec_illegal;

    alu_op_decode u_decode (
        .opcode  (in_opcode),
        .command (dec_command),
        .illegal (dec_illegal)
    );

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);

    // Request/execute/hold sequencing; reset wins in every state and drops any op in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            ovf_en_reg   <= 1'b0;
            alu_command  <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_error    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (dec_illegal) begin
                            // Illegal opcodes never reach the ALU; report straight away.
                            out_result   <= '0;
                            out_overflow <= 1'b0;
                            out_error    <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            alu_a       <= in_a;
                            alu_b       <= in_b;
                            alu_command <= dec_command;
                            cnt_reg     <= CNT_W'(ALU_LATENCY);
                            ovf_en_reg  <= op_has_overflow(in_opcode);
                            state_reg   <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        out_result   <= alu_result;
                        out_overflow <= ovf_en_reg & alu_overflow;
                        out_error    <= 1'b0;
                        alu_command  <= '0;
                        state_reg    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result registers keep their value after hand-off until the next capture.
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: two lanes (ALU latency 0 and 3), each with a
// latency-accurate ALU stub, a transaction-level reference model checked every
// cycle, directed scenarios with literal expectations and random traffic.
module tb_alu_issue_ctrl;

    localparam int W = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input int lane, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h", lane, name, act, exp);
    endtask

    // Reference ALU: {overflow, result}. Non-arithmetic ops report overflow=1
    // on purpose so that the controller's masking is exercised.
    function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = 32'hdeadbeef;
        v = 1'b1;
        case (op)
            5'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            5'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a << b[4:0];
            5'd5: r = $unsigned($signed(a) >>> b[4:0]);
            default: v = 1'b0;
        endcase
        return {v, r};
    endfunction

    function automatic logic [4:0] cmd_to_op(input logic [5:0] c);
        case (c)
            6'b000001: return 5'd0;
            6'b000010: return 5'd1;
            6'b000100: return 5'd2;
            6'b001000: return 5'd3;
            6'b010000: return 5'd4;
            6'b100000: return 5'd5;
            default:   return 5'd31;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            localparam int LAT = (gi == 0) ? 0 : 3;

            logic          rst, in_valid, in_ready, out_valid, out_ready;
            logic          alu_overflow, out_overflow, out_error;
            logic [4:0]    in_opcode;
            logic [W-1:0]  in_a, in_b, alu_a, alu_b, alu_result, out_result;
            logic [5:0]    alu_command;
            bit            done = 1'b0;

            alu_issue_ctrl #(.WIDTH(W), .ALU_LATENCY(LAT)) u_dut (
                .clock        (clock),
                .reset        (rst),
                .in_valid     (in_valid),
                .in_ready     (in_ready),
                .in_opcode    (in_opcode),
                .in_a         (in_a),
                .in_b         (in_b),
                .alu_command  (alu_command),
                .alu_a        (alu_a),
                .alu_b        (alu_b),
                .alu_result   (alu_result),
                .alu_overflow (alu_overflow),
                .out_valid    (out_valid),
                .out_ready    (out_ready),
                .out_result   (out_result),
                .out_overflow (out_overflow),
                .out_error    (out_error)
            );

            // ALU stub: result appears LAT cycles after command/operands; junk otherwise.
            logic [32:0] alu_now;
            logic [32:0] alu_pipe [0:3];
            assign alu_now = ref_alu(cmd_to_op(alu_command), alu_a, alu_b);
            always @(posedge clock) begin
                alu_pipe[0] <= alu_now;
                for (int i = 1; i < 4; i++) alu_pipe[i] <= alu_pipe[i-1];
            end
            assign {alu_overflow, alu_result} = (LAT == 0) ? alu_now : alu_pipe[(LAT == 0) ? 0 : LAT - 1];

            // Transaction model: busy for LAT+1 edges after a legal accept, then hold until consumed.
            bit          m_pend = 1'b0, m_hold = 1'b0;
            int          m_left = 0;
            logic [32:0] m_out;
            logic [5:0]  e_cmd;
            logic [31:0] e_a, e_b, e_res;
            logic        e_ov, e_err;

            always @(posedge clock) begin
                if (rst) begin
                    m_pend = 1'b0; m_hold = 1'b0;
                    e_cmd = '0; e_a = '0; e_b = '0; e_res = '0; e_ov = 1'b0; e_err = 1'b0;
                end else if (m_hold) begin
                    if (out_ready) m_hold = 1'b0;
                end else if (m_pend) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_pend = 1'b0; m_hold = 1'b1;
                        e_cmd = '0; e_res = m_out[31:0];
                        e_ov = m_out[32]; e_err = 1'b0;
                    end
                end else if (in_valid) begin
                    if (in_opcode < 5'd6) begin
                        m_pend = 1'b1; m_left = LAT + 1;
                        e_cmd = 6'b1 << in_opcode;
                        e_a = in_a; e_b = in_b;
                        m_out = ref_alu(in_opcode, in_a, in_b);
                        if (in_opcode > 5'd1) m_out[32] = 1'b0;
                    end else begin
                        m_hold = 1'b1;
                        e_res = '0; e_ov = 1'b0; e_err = 1'b1;
                    end
                end
                #1;
                chk(gi, "in_ready",     in_ready,     !(m_pend || m_hold));
                chk(gi, "out_valid",    out_valid,    m_hold);
                chk(gi, "alu_command",  alu_command,  e_cmd);
                chk(gi, "alu_a",        alu_a,        e_a);
                chk(gi, "alu_b",        alu_b,        e_b);
                chk(gi, "out_result",   out_result,   e_res);
                chk(gi, "out_overflow", out_overflow, e_ov);
                chk(gi, "out_error",    out_error,    e_err);
            end

            // Hold a request until accepted; returns accept cycle and the command seen right after.
            task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int acc, output logic [5:0] fc);
                int n;
                n = 0;
                in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
                while (!in_ready && n < 100) begin @(negedge clock); n++; end
                if (n >= 100) chk(gi, "accept_timeout", 0, 1);
                @(posedge clock);
                @(negedge clock);
                acc = cyc;
                fc = alu_command;
                in_valid = 1'b0;
            endtask

            // Wait for out_valid, counting cycles with a live command.
            task automatic wait_valid(output int vc, output int cmdc);
                int n;
                n = 0; cmdc = 0;
                while (!out_valid && n < 100) begin
                    if (alu_command != '0) cmdc++;
                    @(negedge clock);
                    n++;
                end
                if (n >= 100) chk(gi, "valid_timeout", 0, 1);
                vc = cyc;
            endtask

            task automatic pop();
                out_ready = 1'b1;
                @(negedge clock);
                out_ready = 1'b0;
            endtask

            function automatic logic [31:0] pick();
                case ($urandom_range(0, 3))
                    0: return 32'h8000_0000;
                    1: return 32'h7fff_ffff;
                    default: return $urandom;
                endcase
            endfunction

            initial begin : stim
                int acc, vc, cmdc, rel, prev;
                logic [5:0] fc;
                rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
                repeat (3) @(negedge clock);
                rst = 1'b0;
                chk(gi, "reset_in_ready", in_ready, 1);
                chk(gi, "reset_out_valid", out_valid, 0);
                chk(gi, "reset_command", alu_command, 0);

                // ADD 5+7
                issue(5'd0, 32'd5, 32'd7, acc, fc);
                wait_valid(vc, cmdc);
                chk(gi, "add_cmd", fc, 6'b000001);
                chk(gi, "add_latency", vc - acc, LAT + 1);
                chk(gi, "add_cmd_cycles", cmdc, LAT + 1);
                chk(gi, "add_result", out_result, 12);
                chk(gi, "add_ovf", out_overflow, 0);
                chk(gi, "add_err", out_error, 0);
                pop();

                // SUB with signed overflow
                issue(5'd1, 32'h8000_0000, 32'd1, acc, fc);
                wait_valid(vc, cmdc);
                chk(gi, "sub_cmd", fc, 6'b000010);
                chk(gi, "sub_cmd_cycles", cmdc, LAT + 1);
                chk(gi, "sub_result", out_result, 32'h7fff_ffff);
                chk(gi, "sub_ovf", out_overflow, 1);
                pop();

                // Illegal opcode
                issue(5'd7, 32'h1234, 32'h5678, acc, fc);
                wait_valid(vc, cmdc);
                chk(gi, "ill_cmd", fc, 0);
                chk(gi, "ill_latency", vc - acc, 0);
                chk(gi, "ill_cmd_cycles", cmdc, 0);
                chk(gi, "ill_err", out_error, 1);
                chk(gi, "ill_result", out_result, 0);
                pop();

                // AND clears the error; overflow from the ALU must be masked
                issue(5'd2, 32'hffff_0f0f, 32'h0ff0_ffff, acc, fc);
                wait_valid(vc, cmdc);
                chk(gi, "and_cmd", fc, 6'b000100);
                chk(gi, "and_result", out_result, 32'h0ff0_0f0f);
                chk(gi, "and_err", out_error, 0);
                chk(gi, "and_ovf", out_overflow, 0);

                // Stall in DONE with a pending request
                in_valid = 1'b1; in_opcode = 5'd3; in_a = 32'h00f0; in_b = 32'h0f00;
                repeat (10) begin
                    @(negedge clock);
                    chk(gi, "stall_in_ready", in_ready, 0);
                    chk(gi, "stall_out_valid", out_valid, 1);
                    chk(gi, "stall_result", out_result, 32'h0ff0_0f0f);
                end
                pop();
                rel = cyc;
                chk(gi, "release_in_ready", in_ready, 1);
                chk(gi, "release_out_valid", out_valid, 0);
                issue(5'd3, 32'h00f0, 32'h0f00, acc, fc);
                chk(gi, "release_accept_delay", acc - rel, 1);
                chk(gi, "or_cmd", fc, 6'b001000);
                wait_valid(vc, cmdc);
                chk(gi, "or_result", out_result, 32'h0ff0);
                pop();

                // Reset while executing drops the op
                issue(5'd0, 32'd1, 32'd1, acc, fc);
                rst = 1'b1;
                @(negedge clock);
                rst = 1'b0;
                chk(gi, "abort_in_ready", in_ready, 1);
                chk(gi, "abort_out_valid", out_valid, 0);
                chk(gi, "abort_cmd", alu_command, 0);
                chk(gi, "abort_alu_a", alu_a, 0);
                chk(gi, "abort_result", out_result, 0);
                repeat (LAT + 4) begin
                    @(negedge clock);
                    chk(gi, "abort_no_valid", out_valid, 0);
                end

                // Back-to-back with out_ready held high
                out_ready = 1'b1;
                issue(5'd4, 32'd1, 32'd4, acc, fc);
                chk(gi, "sll_cmd", fc, 6'b010000);
                wait_valid(vc, cmdc);
                chk(gi, "sll_result", out_result, 32'd16);
                prev = acc;
                issue(5'd5, 32'h8000_0000, 32'd4, acc, fc);
                chk(gi, "sra_cmd", fc, 6'b100000);
                chk(gi, "sra_period", acc - prev, LAT + 3);
                wait_valid(vc, cmdc);
                chk(gi, "sra_result", out_result, 32'hf800_0000);
                prev = acc;
                issue(5'd3, 32'h00f0, 32'h0f00, acc, fc);
                chk(gi, "or2_cmd", fc, 6'b001000);
                chk(gi, "or2_period", acc - prev, LAT + 3);
                wait_valid(vc, cmdc);
                chk(gi, "or2_result", out_result, 32'h0ff0);
                @(negedge clock);
                out_ready = 1'b0;

                // Random traffic, checked cycle by cycle against the model
                for (int i = 0; i < 1500; i++) begin
                    @(negedge clock);
                    rst       = ($urandom_range(0, 199) == 0);
                    in_valid  = ($urandom_range(0, 2) != 0);
                    in_opcode = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5));
                    in_a      = pick();
                    in_b      = pick();
                    out_ready = ($urandom_range(0, 1) == 1);
                end
                @(negedge clock);
                rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                repeat (2) @(negedge clock);
                done = 1'b1;
            end
        end
    endgenerate

    initial begin : finisher
        int n;
        n = 0;
        while (!(g_lane[0].done && g_lane[1].done) && n < 50000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50000) begin
            n_checks++;
            $display("FAIL run_timeout: got %0d cycles expected fewer than 50000", n);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
